// File: rtl/periph_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : periph_bus_arbiter
// Purpose  : Shares the single peripheral data bus (DM, Timer0, Timer1 behind
//            the bridge) between two masters: M0 (CPU data port) and M1
//            (auxiliary master: DMA / debug loader). Round-robin grant,
//            per-region wait-state sequencing, req/ack handshake and
//            read-data capture.
//
// Parameters:
//   WAIT_DM   extra ACCESS cycles for the DM region        (default 0)
//   WAIT_TMR  extra ACCESS cycles for Timer0/Timer1         (default 1)
//   CNT_W     wait counter width; WAIT_* must be < 2**CNT_W (default 4)
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   m{0,1}_req                 request, held until the matching ack
//   m{0,1}_addr/wdata/byteen   byte address, write data, byte enables
//                              (byteen == 0 means read)
//   m{0,1}_ack                 one-cycle completion pulse
//   m{0,1}_rdata               read data, non-zero only in the ack cycle
//   m{0,1}_err                 bus-error pulse alongside ack on unmapped
//                              accesses (ARB_BUSERR_EN builds only, else 0)
//   s_valid/addr/wdata/byteen  bridge-side transaction
//   s_rdata                    bridge read mux
//
// Build option:
//   ARB_BUSERR_EN  when defined, unmapped accesses raise m*_err with the ack
//                  and the first unmapped address is held in a sticky
//                  register until reset. Undefined: m*_err tied to 0.
//
// Revision : 1.0  initial release
// ============================================================================
module periph_bus_arbiter #(
  parameter int WAIT_DM  = 0,
  parameter int WAIT_TMR = 1,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  // master 0 (CPU data port)
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  // master 1 (auxiliary master)
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  // bridge side
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_byteen,
  input  logic [31:0] s_rdata
);

  localparam logic [CNT_W-1:0] c_wait_dm  = CNT_W'(WAIT_DM);
  localparam logic [CNT_W-1:0] c_wait_tmr = CNT_W'(WAIT_TMR);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Region decode
  // --------------------------------------------------------------------------
  function automatic logic in_dm(input logic [31:0] a);
    return (a <= 32'h0000_2FFF);
  endfunction

  function automatic logic in_tmr(input logic [31:0] a);
    return ((a >= 32'h0000_7F00) && (a <= 32'h0000_7F0B)) ||
           ((a >= 32'h0000_7F10) && (a <= 32'h0000_7F1B));
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [CNT_W-1:0] wait_q,     wait_d;
  logic             last_q,     last_d;     // id of the last master served
  logic             id_q,       id_d;       // id of the granted master
  logic [31:0]      addr_q,     addr_d;
  logic [31:0]      wdata_q,    wdata_d;
  logic [3:0]       byteen_q,   byteen_d;

  // registered outputs
  logic             s_valid_q,  s_valid_d;
  logic [3:0]       s_byteen_q, s_byteen_d;
  logic [31:0]      s_addr_q,   s_addr_d;
  logic [31:0]      s_wdata_q,  s_wdata_d;
  logic             m0_ack_q,   m0_ack_d;
  logic             m1_ack_q,   m1_ack_d;
  logic [31:0]      m0_rdata_q, m0_rdata_d;
  logic [31:0]      m1_rdata_q, m1_rdata_d;

  // --------------------------------------------------------------------------
  // Grant selection (only consulted in IDLE)
  // --------------------------------------------------------------------------
  logic        gnt_any;
  logic        gnt_id;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_byteen;
  logic        sel_is_dm;
  logic        sel_mapped;
  logic [31:0] cap_rdata;

  assign gnt_any    = m0_req | m1_req;
  // On a tie the master that was not served last wins; last resets to 1 so
  // M0 takes the first tie after reset.
  assign gnt_id     = (m0_req & m1_req) ? ~last_q : m1_req;
  assign sel_addr   = gnt_id ? m1_addr   : m0_addr;
  assign sel_wdata  = gnt_id ? m1_wdata  : m0_wdata;
  assign sel_byteen = gnt_id ? m1_byteen : m0_byteen;
  assign sel_is_dm  = in_dm(sel_addr);
  assign sel_mapped = sel_is_dm | in_tmr(sel_addr);

  // Writes return zero; reads take the bridge mux in the final ACCESS cycle.
  assign cap_rdata  = (byteen_q == 4'b0000) ? s_rdata : 32'h0000_0000;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    last_d     = last_q;
    id_d       = id_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    byteen_d   = byteen_q;
    // bus address/data hold their last values between transfers
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    // strobes and response data default to zero
    s_valid_d  = 1'b0;
    s_byteen_d = 4'b0000;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = 32'h0000_0000;
    m1_rdata_d = 32'h0000_0000;

    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          id_d     = gnt_id;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          byteen_d = sel_byteen;
          wait_d   = sel_is_dm ? c_wait_dm : c_wait_tmr;
          cnt_d    = '0;
          if (sel_mapped) begin
            state_d    = ST_ACCESS;
            s_valid_d  = 1'b1;
            s_byteen_d = sel_byteen;
            s_addr_d   = sel_addr;
            s_wdata_d  = sel_wdata;
          end else begin
            // Unmapped: skip the bus entirely, respond next cycle with zero.
            state_d  = ST_RESP;
            m0_ack_d = ~gnt_id;
            m1_ack_d = gnt_id;
          end
        end
      end

      ST_ACCESS: begin
        if (cnt_q == wait_q) begin
          state_d = ST_RESP;
          if (id_q) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = cap_rdata;
          end else begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = cap_rdata;
          end
        end else begin
          // Byte enables are re-presented on every wait cycle; the
          // peripherals tolerate repeated identical writes.
          cnt_d      = cnt_q + c_cnt_one;
          s_valid_d  = 1'b1;
          s_byteen_d = byteen_q;
        end
      end

      ST_RESP: begin
        last_d  = id_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wait_q     <= '0;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      byteen_q   <= 4'b0000;
      s_valid_q  <= 1'b0;
      s_byteen_q <= 4'b0000;
      s_addr_q   <= 32'h0000_0000;
      s_wdata_q  <= 32'h0000_0000;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= 32'h0000_0000;
      m1_rdata_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      last_q     <= last_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      byteen_q   <= byteen_d;
      s_valid_q  <= s_valid_d;
      s_byteen_q <= s_byteen_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign s_valid  = s_valid_q;
  assign s_byteen = s_byteen_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

  // --------------------------------------------------------------------------
  // Optional bus-error reporting
  // --------------------------------------------------------------------------
`ifdef ARB_BUSERR_EN
  logic        unmapped_hit;
  logic        m0_err_q,   m0_err_d;
  logic        m1_err_q,   m1_err_d;
  logic        err_seen_q, err_seen_d;
  logic [31:0] err_addr_q, err_addr_d;

  // The error pulse is timed to coincide with the ack that the IDLE->RESP
  // shortcut produces for an unmapped grant.
  assign unmapped_hit = (state_q == ST_IDLE) && gnt_any && !sel_mapped;

  always_comb begin
    m0_err_d   = unmapped_hit & ~gnt_id;
    m1_err_d   = unmapped_hit &  gnt_id;
    err_seen_d = err_seen_q;
    err_addr_d = err_addr_q;
    // Sticky: only the first offending address is kept.
    if (unmapped_hit && !err_seen_q) begin
      err_seen_d = 1'b1;
      err_addr_d = sel_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      err_seen_q <= 1'b0;
      err_addr_q <= 32'h0000_0000;
    end else begin
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
      err_seen_q <= err_seen_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign m0_err = m0_err_q;
  assign m1_err = m1_err_q;
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

endmodule
`default_nettype wire
